// File: rtl/mod_multimode_pkg.sv
// Shared types for the multimode modulator: modulation selector and FSM states.
package mod_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BPSK = 2'd0;
  localparam mode_t MODE_BFSK = 2'd1;
  localparam mode_t MODE_OOK  = 2'd2;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

endpackage

// File: rtl/mod_multimode_if.sv
// Bit-stream input handshake and carrier-sample output of the modulator.
interface mod_multimode_if
  import mod_pkg::*;
#(
  parameter int OUT_W = 8
);
  mode_t            mode;
  logic             bit_valid;
  logic             bit_in;
  logic             bit_ready;
  logic [OUT_W-1:0] wav_out;
  logic             wav_valid;
  logic             sym_start;

  modport master (
    output mode, bit_valid, bit_in,
    input  bit_ready, wav_out, wav_valid, sym_start
  );

  modport slave (
    input  mode, bit_valid, bit_in,
    output bit_ready, wav_out, wav_valid, sym_start
  );
endinterface

// File: rtl/mod_sine_lut.sv
// Combinational offset-binary sine ROM; contents are fixed at elaboration time.
module mod_sine_lut #(
  parameter int OUT_W  = 8,
  parameter int LUT_AW = 6
) (
  input  logic [LUT_AW-1:0] addr,
  output logic [OUT_W-1:0]  data
);
  localparam int DEPTH = 1 << LUT_AW;
  localparam int MID   = 1 << (OUT_W - 1);

  logic [OUT_W-1:0] rom [DEPTH];

  // Amplitude MID-1 keeps the peak inside OUT_W; rounding is to nearest, halves away from zero.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam real ANG = 2.0 * 3.141592653589793 * real'(gi) / real'(DEPTH);
    localparam real AMP = real'(MID - 1) * $sin(ANG);
    localparam int  VAL = (AMP >= 0.0) ? (MID + $rtoi(AMP + 0.5)) : (MID - $rtoi(0.5 - AMP));
    assign rom[gi] = OUT_W'(VAL);
  end

  assign data = rom[addr];
endmodule

// File: rtl/mod_multimode.sv
// Single-clock BPSK/BFSK/OOK modulator: one latched bit per SPS-sample symbol.
module mod_multimode
  import mod_pkg::*;
#(
  parameter int OUT_W   = 8,
  parameter int SPS     = 16,
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 6,
  parameter int F0_INC  = 4096,
  parameter int F1_INC  = 8192
) (
  input logic            clk_fast,
  input logic            rst,
  mod_multimode_if.slave bus
);
  localparam int                 CNT_W     = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SPS - 1);
  localparam logic [OUT_W-1:0]   MID       = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [PHASE_W-1:0] HALF_TURN = {1'b1, {(PHASE_W-1){1'b0}}};
  localparam logic [PHASE_W-1:0] INC0      = PHASE_W'(F0_INC);
  localparam logic [PHASE_W-1:0] INC1      = PHASE_W'(F1_INC);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [PHASE_W-1:0] acc_reg, acc_next;
  logic               bit_reg, bit_next;
  mode_t              mode_reg, mode_next;
  logic [OUT_W-1:0]   wav_out_reg, wav_next;
  logic               wav_valid_reg;
  logic               sym_start_reg;

  logic               last_sample;
  logic               ready;
  logic               transfer;
  logic [PHASE_W-1:0] phase_inc;
  logic [PHASE_W-1:0] phase_off;
  logic [PHASE_W-1:0] phase_sum;
  logic               bpsk_like;
  logic [LUT_AW-1:0]  lut_addr;
  logic [OUT_W-1:0]   lut_data;

  mod_sine_lut #(
    .OUT_W (OUT_W),
    .LUT_AW(LUT_AW)
  ) u_lut (
    .addr(lut_addr),
    .data(lut_data)
  );

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      bit_reg       <= 1'b0;
      mode_reg      <= MODE_BPSK;
      wav_out_reg   <= MID;
      wav_valid_reg <= 1'b0;
      sym_start_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      bit_reg       <= bit_next;
      mode_reg      <= mode_next;
      wav_out_reg   <= wav_next;
      wav_valid_reg <= (state_next == ST_RUN);
      sym_start_reg <= transfer;
    end
  end

  always_comb begin
    last_sample = (state_reg == ST_RUN) && (cnt_reg == CNT_LAST);
    ready       = !rst && ((state_reg == ST_IDLE) || last_sample);
    transfer    = ready && bus.bit_valid;
    phase_inc   = ((mode_reg == MODE_BFSK) && bit_reg) ? INC1 : INC0;

    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    bit_next   = bit_reg;
    mode_next  = mode_reg;

    case (state_reg)
      ST_IDLE: begin
        if (transfer) begin
          state_next = ST_RUN;
          cnt_next   = '0;
          acc_next   = '0;
          bit_next   = bus.bit_in;
          mode_next  = bus.mode;
        end
      end
      ST_RUN: begin
        acc_next = acc_reg + phase_inc;
        cnt_next = cnt_reg + 1'b1;
        if (last_sample) begin
          cnt_next = '0;
          if (transfer) begin
            bit_next  = bus.bit_in;
            mode_next = bus.mode;
          end else begin
            // Bursts always restart at phase 0.
            state_next = ST_IDLE;
            acc_next   = '0;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The output register is loaded with the sample belonging to the upcoming cycle.
  always_comb begin
    bpsk_like = (mode_next != MODE_BFSK) && (mode_next != MODE_OOK);
    phase_off = (bpsk_like && !bit_next) ? HALF_TURN : '0;
    phase_sum = acc_next + phase_off;
    if (state_next != ST_RUN) begin
      wav_next = MID;
    end else if ((mode_next == MODE_OOK) && !bit_next) begin
      wav_next = MID;
    end else begin
      wav_next = lut_data;
    end
  end

  assign lut_addr      = phase_sum[PHASE_W-1 -: LUT_AW];
  assign bus.bit_ready = ready;
  assign bus.wav_out   = wav_out_reg;
  assign bus.wav_valid = wav_valid_reg;
  assign bus.sym_start = sym_start_reg;
endmodule

// File: tb/tb_mod_multimode.sv
// Directed bench for mod_multimode: BPSK, BFSK, OOK streams, mode switch and mid-symbol reset.
module tb_mod_multimode;
  import mod_pkg::*;

  logic clk_fast = 1'b0;
  logic rst      = 1'b1;
  int   checks   = 0;
  int   errors   = 0;

  // Carrier at F0_INC: LUT indices 0,4,...,60 of the 64-entry table.
  int s1 [16] = '{128, 177, 218, 245, 255, 245, 218, 177, 128, 79, 38, 11, 1, 11, 38, 79};
  int bits_fsk [3] = '{0, 1, 1};
  int bits_ook [3] = '{1, 0, 1};

  mod_multimode_if #(.OUT_W(8)) bus ();

  mod_multimode #(
    .OUT_W  (8),
    .SPS    (16),
    .PHASE_W(16),
    .LUT_AW (6),
    .F0_INC (4096),
    .F1_INC (8192)
  ) dut (
    .clk_fast(clk_fast),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_fast = ~clk_fast;

  task automatic step();
    @(posedge clk_fast);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_sample(input string tag, input int k, input int exp_wav, input logic exp_rdy);
    chk($sformatf("%s_wav_k%0d", tag, k), {24'd0, bus.wav_out}, exp_wav);
    chk($sformatf("%s_valid_k%0d", tag, k), {31'd0, bus.wav_valid}, 1);
    chk($sformatf("%s_start_k%0d", tag, k), {31'd0, bus.sym_start}, (k == 0) ? 1 : 0);
    chk($sformatf("%s_ready_k%0d", tag, k), {31'd0, bus.bit_ready}, {31'd0, exp_rdy});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wav"}, {24'd0, bus.wav_out}, 128);
    chk({tag, "_valid"}, {31'd0, bus.wav_valid}, 0);
    chk({tag, "_start"}, {31'd0, bus.sym_start}, 0);
  endtask

  initial begin
    bus.mode      = MODE_BPSK;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    rst           = 1'b1;
    step();
    step();
    chk_idle("reset");
    chk("reset_ready", {31'd0, bus.bit_ready}, 0);
    rst = 1'b0;
    #1;
    chk("idle_ready", {31'd0, bus.bit_ready}, 1);

    // BPSK single bit 1
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    step();
    bus.bit_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_sample("bpsk1", k, s1[k], k == 15);
      step();
    end
    chk_idle("bpsk1_after");
    $display("txn bpsk bit=1 samples=16");

    // BPSK single bit 0: carrier shifted by half a turn
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b1;
    step();
    bus.bit_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_sample("bpsk0", k, s1[(k + 8) % 16], k == 15);
      step();
    end
    chk_idle("bpsk0_after");
    $display("txn bpsk bit=0 samples=16");

    // BFSK stream 0,1,1 held valid, next bit presented right after each transfer
    bus.mode      = MODE_BFSK;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b1;
    step();
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 16; k++) begin
        chk_sample($sformatf("bfsk_s%0d", s), k,
                   (bits_fsk[s] == 1) ? s1[(2 * k) % 16] : s1[k], k == 15);
        if (k == 0) begin
          if (s < 2) bus.bit_in = bits_fsk[s + 1][0];
          else       bus.bit_valid = 1'b0;
        end
        step();
      end
      $display("txn bfsk symbol=%0d bit=%0d", s, bits_fsk[s]);
    end
    chk_idle("bfsk_after");

    // OOK stream 1,0,1
    bus.mode      = MODE_OOK;
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    step();
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 16; k++) begin
        chk_sample($sformatf("ook_s%0d", s), k, (bits_ook[s] == 1) ? s1[k] : 128, k == 15);
        if (k == 0) begin
          if (s < 2) bus.bit_in = bits_ook[s + 1][0];
          else       bus.bit_valid = 1'b0;
        end
        step();
      end
      $display("txn ook symbol=%0d bit=%0d", s, bits_ook[s]);
    end
    chk_idle("ook_after");

    // Mode switched to BFSK at sample 7: only the next symbol is BFSK
    bus.mode      = MODE_BPSK;
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      chk_sample("msw_s0", k, s1[k], k == 15);
      if (k == 7) bus.mode = MODE_BFSK;
      step();
    end
    $display("txn modeswitch symbol=0 mode=bpsk");
    for (int k = 0; k < 16; k++) begin
      chk_sample("msw_s1", k, s1[(2 * k) % 16], k == 15);
      if (k == 0) bus.bit_valid = 1'b0;
      step();
    end
    $display("txn modeswitch symbol=1 mode=bfsk");
    chk_idle("msw_after");

    // Reset at sample 5 aborts the symbol; the next burst starts at phase 0
    bus.mode      = MODE_BPSK;
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    step();
    bus.bit_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk_sample("abort", k, s1[k], 1'b0);
      if (k == 5) rst = 1'b1;
      step();
    end
    chk_idle("abort_rst");
    chk("abort_rst_ready", {31'd0, bus.bit_ready}, 0);
    rst = 1'b0;
    #1;
    chk("abort_rel_ready", {31'd0, bus.bit_ready}, 1);
    $display("txn reset mid-symbol at sample 5");
    bus.bit_valid = 1'b1;
    step();
    bus.bit_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_sample("restart", k, s1[k], k == 15);
      step();
    end
    chk_idle("restart_after");
    $display("txn bpsk restart bit=1 samples=16");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
